// File: rtl/prog_lut_fn_pkg.sv
// prog_lut_fn_pkg -- shared definitions for the programmable lookup-table
// function block.
//   lut_state_e : operating mode (RUN evaluates, LOAD reloads the table)
//   N_IN_MAX    : largest supported number of function inputs
//   N_OUT_MAX   : largest supported number of function outputs
package prog_lut_fn_pkg;

    localparam int N_IN_MAX  = 8;
    localparam int N_OUT_MAX = 8;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } lut_state_e;

endpackage

// File: rtl/prog_lut_fn_table.sv
// prog_lut_fn_table -- truth-table storage for prog_lut_fn.
// Holds 2**N_IN entries of N_OUT bits. There is one synchronous write port
// and one combinational read port.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (restores RESET_TABLE)
//   we, waddr, wdata: write enable, entry index, entry value
//   raddr, rdata    : read index, entry value (combinational)
module prog_lut_fn_table #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] RESET_TABLE = 'h31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [N_IN-1:0]  waddr,
    input  logic [N_OUT-1:0] wdata,
    input  logic [N_IN-1:0]  raddr,
    output logic [N_OUT-1:0] rdata
);

    localparam int DEPTH = 2**N_IN;

    logic [N_OUT-1:0] mem [DEPTH];

    // NOTE: the table is reset on purpose. Reset must restore the default
    // function, including after a reload that was only partly written. This
    // makes the storage a register array, not RAM, which is acceptable at
    // 256 x 8 bits at most.
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_TABLE[i*N_OUT +: N_OUT];
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut_fn.sv
// prog_lut_fn -- programmable N_IN -> N_OUT boolean function.
// Each accepted input vector indexes the truth table. The result is
// registered, so it appears exactly one cycle later. The table can be
// reloaded in place: a cfg_start pulse enters LOAD, and then 2**N_IN cfg_valid
// beats write the entries in order, starting from entry 0.
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   in_valid, in_ready, in_data  : evaluation request handshake
//   out_valid, out_ready, out_data: result handshake
//   cfg_start                    : pulse that begins a reload
//   cfg_valid, cfg_data          : reload beats
//   cfg_busy                     : high while reloading
//   cfg_done                     : one-cycle pulse on the first RUN cycle after a reload
module prog_lut_fn
    import prog_lut_fn_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] RESET_TABLE = 'h31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             cfg_busy,
    output logic             cfg_done
);

    // The counter is one bit wider than the index so it can represent the
    // full entry count without wrapping inside a load.
    localparam logic [N_IN:0] LAST_ADDR = (N_IN+1)'(2**N_IN - 1);

    lut_state_e       state, state_next;
    logic [N_IN:0]    addr;
    logic             accept;
    logic             beat;
    logic             last_beat;
    logic [N_OUT-1:0] rdata;

    assign in_ready  = (state == RUN) & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign beat      = (state == LOAD) & cfg_valid;
    assign last_beat = beat & (addr == LAST_ADDR);

    // Writes happen only in LOAD. An input accepted in the same cycle as
    // cfg_start therefore still reads the old table.
    prog_lut_fn_table #(
        .N_IN        (N_IN),
        .N_OUT       (N_OUT),
        .RESET_TABLE (RESET_TABLE)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (beat),
        .waddr (addr[N_IN-1:0]),
        .wdata (cfg_data),
        .raddr (in_data),
        .rdata (rdata)
    );

    // NOTE: every output of this process gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        cfg_busy   = 1'b0;
        case (state)
            RUN: begin
                if (cfg_start) state_next = LOAD;
            end
            LOAD: begin
                cfg_busy = 1'b1;
                if (last_beat) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            addr     <= '0;
            cfg_done <= 1'b0;
        end else begin
            state    <= state_next;
            // cfg_done is registered from the last beat, so it lines up
            // with the first RUN cycle.
            cfg_done <= last_beat;
            if (last_beat) begin
                addr <= '0;
            end else if (beat) begin
                addr <= addr + (N_IN+1)'(1);
            end
        end
    end

    // Output register. A pending result is held until it is consumed, and
    // a reload does not affect it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= rdata;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_lut_fn.sv
// tb_prog_lut_fn -- directed scoreboard bench for prog_lut_fn.
// Instance a uses the default parameters (3 -> 1, table 'h31).
// Instance b uses N_IN=4 and N_OUT=2.
// Drivers push the hand-computed expected results when an input is
// accepted. Per-instance monitors pop and compare on every output handshake.
module tb_prog_lut_fn;

    typedef struct {
        logic [7:0] data;
        int         acc_cyc;
        bit         chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // instance a
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0] a_in_data;
    logic [0:0] a_out_data, a_cfg_data;
    logic       a_cfg_start, a_cfg_valid, a_cfg_busy, a_cfg_done;
    // instance b
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_in_data;
    logic [1:0] b_out_data, b_cfg_data;
    logic       b_cfg_start, b_cfg_valid, b_cfg_busy, b_cfg_done;

    prog_lut_fn u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .cfg_start(a_cfg_start), .cfg_valid(a_cfg_valid), .cfg_data(a_cfg_data),
        .cfg_busy(a_cfg_busy), .cfg_done(a_cfg_done)
    );

    prog_lut_fn #(.N_IN(4), .N_OUT(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid), .cfg_data(b_cfg_data),
        .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done)
    );

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int hs_a = 0, hs_b = 0, done_a = 0, done_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitors: sample mid-cycle, the handshake completes on the next edge
    always @(negedge clk) begin
        if (!reset && a_out_valid && a_out_ready) begin
            hs_a++;
            if (qa.size() == 0) begin
                check("a_unexpected_result", 32'(a_out_data), 32'hffff_ffff);
            end else begin
                ea = qa.pop_front();
                check("a_out_data", 32'(a_out_data), 32'(ea.data));
                if (ea.chk_lat) check("a_latency", cyc, ea.acc_cyc + 1);
            end
        end
        if (!reset && a_cfg_done) done_a++;
    end

    always @(negedge clk) begin
        if (!reset && b_out_valid && b_out_ready) begin
            hs_b++;
            if (qb.size() == 0) begin
                check("b_unexpected_result", 32'(b_out_data), 32'hffff_ffff);
            end else begin
                eb = qb.pop_front();
                check("b_out_data", 32'(b_out_data), 32'(eb.data));
                if (eb.chk_lat) check("b_latency", cyc, eb.acc_cyc + 1);
            end
        end
        if (!reset && b_cfg_done) done_b++;
    end

    task automatic send_a(input logic [2:0] d, input logic [7:0] e, input bit lat);
        bit got = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back('{data: e, acc_cyc: cyc, chk_lat: lat});
                got = 1;
            end
        end
        if (!got) check("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] d, input logic [7:0] e, input bit lat);
        bit got = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_in_ready) begin
                qb.push_back('{data: e, acc_cyc: cyc, chk_lat: lat});
                got = 1;
            end
        end
        if (!got) check("b_accept_timeout", 0, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 50 && qa.size() != 0; i++) @(posedge clk);
        #1;
        check("a_drain_left", qa.size(), 0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 50 && qb.size() != 0; i++) @(posedge clk);
        #1;
        check("b_drain_left", qb.size(), 0);
    endtask

    task automatic cfg_beat_a(input logic [0:0] d);
        a_cfg_valid = 1'b1;
        a_cfg_data  = d;
        @(posedge clk); #1;
        a_cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, d0;
        reset = 1'b1;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1; a_cfg_start = 0; a_cfg_valid = 0; a_cfg_data = '0;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 1; b_cfg_start = 0; b_cfg_valid = 0; b_cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("a_rst_out_valid", 32'(a_out_valid), 0);
        check("a_rst_out_data",  32'(a_out_data), 0);
        check("a_rst_cfg_busy",  32'(a_cfg_busy), 0);
        check("a_rst_cfg_done",  32'(a_cfg_done), 0);
        check("b_rst_out_valid", 32'(b_out_valid), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("a_rst_in_ready", 32'(a_in_ready), 1);
        check("b_rst_in_ready", 32'(b_in_ready), 1);

        // default table 'h31: entries 1,0,0,0,1,1,0,0
        send_a(3'b000, 1, 1);
        send_a(3'b001, 0, 1);
        send_a(3'b100, 1, 1);
        send_a(3'b101, 1, 1);
        send_a(3'b111, 0, 1);
        drain_a();

        // backpressure: the result must hold and inputs must be blocked
        a_out_ready = 1'b0;
        send_a(3'b100, 1, 0);
        a_in_valid = 1'b1;
        a_in_data  = 3'b000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("a_stall_in_ready",  32'(a_in_ready), 0);
            check("a_stall_out_valid", 32'(a_out_valid), 1);
            check("a_stall_out_data",  32'(a_out_data), 1);
        end
        a_in_valid = 1'b0;
        hs0 = hs_a;
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("a_release_handshakes", hs_a - hs0, 1);
        check("a_release_out_valid", 32'(a_out_valid), 0);
        check("a_release_queue", qa.size(), 0);

        // accept together with cfg_start reads the old table (entry 1 = 0).
        // The result is left pending across the reload.
        a_in_valid = 1'b1; a_in_data = 3'b001; a_cfg_start = 1'b1;
        @(negedge clk);
        check("a_start_accept_ready", 32'(a_in_ready), 1);
        qa.push_back('{data: 0, acc_cyc: cyc, chk_lat: 0});
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_cfg_start = 1'b0;
        d0 = done_a;
        for (int i = 0; i < 8; i++) begin
            check("a_load_busy", 32'(a_cfg_busy), 1);
            if (i == 4) begin
                check("a_load_pending_valid", 32'(a_out_valid), 1);
                check("a_load_pending_data",  32'(a_out_data), 0);
            end
            if (i == 5) a_out_ready = 1'b1;
            if (i == 6) check("a_load_in_ready", 32'(a_in_ready), 0);
            cfg_beat_a(1'b1);
            if (i == 7) begin
                check("a_load_end_busy", 32'(a_cfg_busy), 0);
                check("a_load_end_done", 32'(a_cfg_done), 1);
            end else begin
                a_cfg_start = (i == 2);  // must be ignored in LOAD
                @(posedge clk); #1;
                a_cfg_start = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("a_done_cleared", 32'(a_cfg_done), 0);
        check("a_done_pulses", done_a - d0, 1);
        check("a_pending_consumed", qa.size(), 0);
        // cfg_valid in RUN must not write entry 0
        cfg_beat_a(1'b0);
        check("a_run_cfg_busy", 32'(a_cfg_busy), 0);
        send_a(3'b001, 1, 1);
        send_a(3'b000, 1, 1);
        send_a(3'b110, 1, 1);
        drain_a();

        // reset in the middle of a reload restores the default table
        a_cfg_start = 1'b1;
        @(posedge clk); #1;
        a_cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) cfg_beat_a(1'b0);
        check("a_midload_busy", 32'(a_cfg_busy), 1);
        reset = 1'b1;
        #1;
        check("a_midreset_busy", 32'(a_cfg_busy), 0);
        check("a_midreset_done", 32'(a_cfg_done), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check("a_midreset_in_ready", 32'(a_in_ready), 1);
        send_a(3'b000, 1, 1);
        send_a(3'b001, 0, 1);
        send_a(3'b110, 0, 1);
        send_a(3'b101, 1, 1);
        drain_a();

        // instance b: default 'h31 gives entries 01,00,11,00,...
        send_b(4'b0000, 1, 1);
        send_b(4'b0010, 3, 1);
        send_b(4'b0001, 0, 1);
        drain_b();
        b_cfg_start = 1'b1;
        @(posedge clk); #1;
        b_cfg_start = 1'b0;
        d0 = done_b;
        for (int i = 0; i < 16; i++) begin
            check("b_load_busy", 32'(b_cfg_busy), 1);
            if (i == 15) check("b_done_early", done_b - d0, 0);
            b_cfg_valid = 1'b1;
            b_cfg_data  = 2'(i % 4);
            @(posedge clk); #1;
        end
        b_cfg_valid = 1'b0;
        check("b_load_end_busy", 32'(b_cfg_busy), 0);
        check("b_load_end_done", 32'(b_cfg_done), 1);
        @(posedge clk); #1;
        check("b_done_pulses", done_b - d0, 1);
        send_b(4'b1110, 2, 1);
        send_b(4'b0101, 1, 1);
        send_b(4'b0011, 3, 1);
        send_b(4'b1000, 0, 1);
        drain_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_lut_fn.md
PROG_LUT_FN -- requirements
Module: prog_lut_fn

Interface
REQ-001 SHALL have parameter N_IN, default 3: number of function inputs, legal 1..8.
REQ-002 SHALL have parameter N_OUT, default 1: number of function outputs, legal 1..8.
REQ-003 SHALL have parameter RESET_TABLE, default 'h31: reset truth table, entry i at bits [i*N_OUT +: N_OUT].
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  evaluation request valid.
REQ-007 in_ready  output  1  evaluation request accepted when in_valid & in_ready.
REQ-008 in_data  input  N_IN  function inputs; bit N_IN-1 is the MSB of the table index.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-011 out_data  output  N_OUT  function result.
REQ-012 cfg_start  input  1  single-cycle pulse that begins a table reload.
REQ-013 cfg_valid  input  1  reload beat valid.
REQ-014 cfg_data  input  N_OUT  table entry for the current reload beat.
REQ-015 cfg_busy  output  1  high while in LOAD.
REQ-016 cfg_done  output  1  one-cycle pulse when a reload completes.

Function
REQ-017 SHALL hold a table of 2**N_IN entries of N_OUT bits each.
REQ-018 SHALL implement FSM states RUN and LOAD.
REQ-019 RUN -> LOAD on cfg_start; LOAD -> RUN on the cycle that accepts beat 2**N_IN-1.
REQ-020 cfg_start during LOAD SHALL be ignored.
REQ-021 in_ready = (state==RUN) & (~out_valid | out_ready).
REQ-022 On accept, out_data SHALL be table[in_data] on the next cycle, with out_valid=1; latency exactly 1 cycle.
REQ-023 out_valid/out_data SHALL hold stable while out_valid & ~out_ready.
REQ-024 Full throughput SHALL be 1 result per cycle with out_ready held high.
REQ-025 Accept and cfg_start in the same cycle: the accepted input SHALL use the old table.
REQ-026 A result registered before or during LOAD SHALL remain valid and unchanged until consumed.
REQ-027 In LOAD, each cfg_valid beat SHALL write cfg_data to table[addr], where addr starts at 0 and increments by 1.
REQ-028 cfg_valid in RUN SHALL be ignored.
REQ-029 cfg_done SHALL pulse for one cycle, coincident with the first RUN cycle after LOAD.
REQ-030 The address counter SHALL be N_IN+1 bits wide, with no wrap inside a load.

Reset
REQ-031 Reset values: state RUN, table = RESET_TABLE, address 0, out_valid 0, out_data 0, cfg_busy 0, cfg_done 0.
REQ-032 in_ready SHALL be 1 after reset.
REQ-033 Reset during LOAD SHALL abandon the load; the partially written table is replaced by RESET_TABLE.

Structure
REQ-034 Package prog_lut_fn_pkg SHALL hold the state enum (RUN, LOAD) and the N_IN/N_OUT max-width constants.
REQ-035 Table storage and the write port SHALL live in sub-module prog_lut_fn_table.
REQ-036 The read path SHALL be combinational into the output register; no other pipeline stages.

Verification
REQ-037 Defaults, after reset, in_data 000,001,100,101,111 back-to-back with out_ready=1 -> out_data 1,0,1,1,0 on consecutive cycles, starting 1 cycle after the first accept.
REQ-038 cfg_start, then 8 beats of cfg_data=1 with gaps -> cfg_busy high throughout; cfg_done pulses once after beat 7; in_data 001 then yields 1.
REQ-039 out_ready=0 for 5 cycles with a result pending -> in_ready=0 and out_data stable; release -> exactly one handshake.
REQ-040 in accept of 001 in the same cycle as cfg_start -> result 0 (old table), even though the reload writes all ones.
REQ-041 reset asserted after beat 3 of a reload -> cfg_busy 0; in_data 000 yields 1, 001 yields 0 (RESET_TABLE restored).
REQ-042 N_IN=4, N_OUT=2: load entry i = i[1:0] -> in_data 1110 yields 2'b10; cfg_done pulses after the 16th beat.
